// File: rtl/lvg_pkg.sv
// Shared definitions for the systolic-array result path.
// Holds the sequencer count window that carries result words, the matrix
// dimension, the collector FSM state type and the de-skew lane helper.
package lvg_pkg;

  localparam logic [4:0] CNT_FIRST = 5'd5;
  localparam logic [4:0] CNT_LAST  = 5'd11;
  localparam int         MAT_N     = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } collector_state_t;

  // Which dispatcher lane (0 = d1 .. 3 = d4) carries element (r, c), 0-based.
  // On anti-diagonal s = r + c the lanes start at row 0 while s <= 3 and
  // slide down one row per step after that, so the lane is r early on and
  // (MAT_N - 1 - c) on the lower half of the skew.
  function automatic int src_lane(input int r, input int c);
    if (r + c <= MAT_N - 1) return r;
    else                    return MAT_N - 1 - c;
  endfunction

endpackage

// File: rtl/result_collector.sv
// Result collector: de-skews the dispatcher's anti-diagonal words into a 4x4
// buffer and drains it one row per out_valid/out_ready handshake.
// Ports: clk, rst (async, active-high); count = sequencer count; d1..d4 =
// dispatcher words; out_ready/out_valid/out_row_idx/out_data = row stream;
// busy = not idle; done = last-row pulse; err/ovr = sticky sequencing/overrun flags.
module result_collector
  import lvg_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           count,
  input  logic [WIDTH-1:0]     d1,
  input  logic [WIDTH-1:0]     d2,
  input  logic [WIDTH-1:0]     d3,
  input  logic [WIDTH-1:0]     d4,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [1:0]           out_row_idx,
  output logic [4*WIDTH-1:0]   out_data,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 ovr
);

  collector_state_t state_q, state_d;
  logic [4:0]       cnt_q;
  logic [4:0]       exp_q, exp_d;
  logic [1:0]       row_q, row_d;
  logic             done_q, done_d;
  logic             err_q, ovr_q;
  logic             capture, set_err, set_ovr;

  logic [WIDTH-1:0] buf_q  [MAT_N][MAT_N];
  logic [WIDTH-1:0] d_lane [MAT_N];

  always_comb begin
    d_lane[0] = d1;
    d_lane[1] = d2;
    d_lane[2] = d3;
    d_lane[3] = d4;
  end

  // State, expected-count and row pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      exp_q   <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= count;
      exp_q   <= exp_d;
      row_q   <= row_d;
      done_q  <= done_d;
      if (set_err) err_q <= 1'b1;
      if (set_ovr) ovr_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    row_d   = row_q;
    done_d  = 1'b0;
    capture = 1'b0;
    set_err = 1'b0;
    set_ovr = 1'b0;
    case (state_q)
      IDLE: begin
        if (cnt_q == CNT_FIRST) begin
          capture = 1'b1;
          exp_d   = CNT_FIRST + 5'd1;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (cnt_q == exp_q) begin
          capture = 1'b1;
          exp_d   = exp_q + 5'd1;
          if (cnt_q == CNT_LAST) begin
            row_d   = 2'd0;
            state_d = DRAIN;
          end
        end else if (cnt_q != exp_q - 5'd1) begin
          // A held count (previous value repeated) is tolerated; anything
          // else means the skew is broken and the buffer cannot be trusted.
          set_err = 1'b1;
          state_d = IDLE;
        end
      end
      DRAIN: begin
        // A new matrix arriving before the drain finishes is dropped, not
        // started, even when it coincides with the last-row accept.
        if (cnt_q == CNT_FIRST) set_ovr = 1'b1;
        if (out_ready) begin
          row_d = row_q + 2'd1;
          if (row_q == 2'd3) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // De-skew buffer: element (r, c) lives on anti-diagonal r + c, so it is
  // written when cnt_q selects that diagonal, from the lane carrying it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < MAT_N; r++)
        for (int c = 0; c < MAT_N; c++)
          buf_q[r][c] <= '0;
    end else if (capture) begin
      for (int r = 0; r < MAT_N; r++)
        for (int c = 0; c < MAT_N; c++)
          if (cnt_q == CNT_FIRST + 5'(r + c))
            buf_q[r][c] <= d_lane[src_lane(r, c)];
    end
  end

  assign out_valid   = (state_q == DRAIN);
  assign out_row_idx = row_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign err         = err_q;
  assign ovr         = ovr_q;

  // Row data is forced to zero while no row is presented.
  always_comb begin
    out_data = '0;
    for (int c = 0; c < MAT_N; c++)
      out_data[c*WIDTH +: WIDTH] = out_valid ? buf_q[row_q][c] : '0;
  end

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector: full run, backpressure, held count,
// overrun, count skip and asynchronous reset, all checked against constants
// derived from the element pattern base + 16*row + col.
module tb_result_collector;

  localparam int W = 32;
  localparam logic [31:0] B1 = 32'h3F80_0000;
  localparam logic [31:0] B2 = 32'h4000_0000;
  localparam logic [31:0] B3 = 32'h5000_0000;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [4:0]     count = '0;
  logic [W-1:0]   d1 = '0, d2 = '0, d3 = '0, d4 = '0;
  logic           out_ready = 1'b1;
  logic           out_valid;
  logic [1:0]     out_row_idx;
  logic [4*W-1:0] out_data;
  logic           busy, done, err, ovr;

  int errors = 0;
  int checks = 0;
  int prev_cnt = 0;
  logic [31:0] cur_base = B1;

  result_collector #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .count       (count),
    .d1          (d1),
    .d2          (d2),
    .d3          (d3),
    .d4          (d4),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_row_idx (out_row_idx),
    .out_data    (out_data),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .ovr         (ovr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Element (r, c), 1-based, of the matrix built on base.
  function automatic logic [31:0] elem(input logic [31:0] base, input int r, input int c);
    return base + 32'(16 * r + c);
  endfunction

  // Word the dispatcher places on lane j (1..4) for count k.
  function automatic logic [31:0] dword(input int k, input int j, input logic [31:0] base);
    int s, r0, c0;
    if (k < 5 || k > 11) return 32'h0;
    s  = k - 5;
    r0 = (j - 1) + ((s > 3) ? s - 3 : 0);
    c0 = s - r0;
    if (r0 > 3 || c0 < 0 || c0 > 3) return 32'h0;
    return elem(base, r0 + 1, c0 + 1);
  endfunction

  function automatic logic [127:0] row_exp(input logic [31:0] base, input int r);
    logic [127:0] v;
    v = '0;
    for (int c = 0; c < 4; c++) v[c*32 +: 32] = elem(base, r + 1, c + 1);
    return v;
  endfunction

  // Present count k; d carries the words for the previously presented count,
  // mirroring the dispatcher's one-cycle register. Returns at the next negedge.
  task automatic step(input int k);
    d1 = dword(prev_cnt, 1, cur_base);
    d2 = dword(prev_cnt, 2, cur_base);
    d3 = dword(prev_cnt, 3, cur_base);
    d4 = dword(prev_cnt, 4, cur_base);
    count = 5'(k);
    prev_cnt = k;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_collect(input logic [31:0] base);
    cur_base = base;
    for (int k = 5; k <= 11; k++) step(k);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".valid"}, 128'(out_valid), 128'(0));
    check({tag, ".idx"},   128'(out_row_idx), 128'(0));
    check({tag, ".data"},  128'(out_data), 128'(0));
    check({tag, ".busy"},  128'(busy), 128'(0));
    check({tag, ".done"},  128'(done), 128'(0));
    check({tag, ".err"},   128'(err), 128'(0));
    check({tag, ".ovr"},   128'(ovr), 128'(0));
  endtask

  // Expects to be entered with row 0 presented. Optionally stalls one row.
  task automatic drain(input string tag, input logic [31:0] base, input int stall_row, input int stall_cycles);
    for (int r = 0; r < 4; r++) begin
      check($sformatf("%s.valid%0d", tag, r), 128'(out_valid), 128'(1));
      check($sformatf("%s.idx%0d", tag, r),   128'(out_row_idx), 128'(r));
      check($sformatf("%s.row%0d", tag, r),   128'(out_data), row_exp(base, r));
      check($sformatf("%s.nodone%0d", tag, r), 128'(done), 128'(0));
      if (r == stall_row) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_cycles; s++) begin
          step(0);
          check($sformatf("%s.hold_idx%0d", tag, s),  128'(out_row_idx), 128'(r));
          check($sformatf("%s.hold_row%0d", tag, s),  128'(out_data), row_exp(base, r));
          check($sformatf("%s.hold_vld%0d", tag, s),  128'(out_valid), 128'(1));
        end
      end
      out_ready = 1'b1;
      step(0);
    end
    check({tag, ".end_valid"}, 128'(out_valid), 128'(0));
    check({tag, ".done"},      128'(done), 128'(1));
    check({tag, ".end_busy"},  128'(busy), 128'(0));
    step(0);
    check({tag, ".done_pulse"}, 128'(done), 128'(0));
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    step(0);

    // Full sequence with out_ready held high
    out_ready = 1'b1;
    run_collect(B1);
    check("full.pre_valid", 128'(out_valid), 128'(0));
    check("full.pre_busy",  128'(busy), 128'(1));
    step(0);
    drain("full", B1, -1, 0);

    // Backpressure on row 1
    run_collect(B2);
    step(0);
    drain("bp", B2, 1, 5);

    // Held count 7 for three cycles
    cur_base = B1;
    step(5); step(6); step(7); step(7); step(7);
    step(8); step(9); step(10); step(11);
    check("held.err", 128'(err), 128'(0));
    step(0);
    drain("held", B1, -1, 0);
    check("held.err_after", 128'(err), 128'(0));

    // Overrun: a new matrix arrives while row 0 is stalled
    run_collect(B1);
    out_ready = 1'b0;
    step(0);
    check("ovr.valid", 128'(out_valid), 128'(1));
    cur_base = B3;
    step(5); step(6); step(7); step(0);
    check("ovr.flag",  128'(ovr), 128'(1));
    check("ovr.idx",   128'(out_row_idx), 128'(0));
    check("ovr.err",   128'(err), 128'(0));
    drain("ovr", B1, -1, 0);
    check("ovr.sticky", 128'(ovr), 128'(1));

    // Count skip 5, 6, 8
    cur_base = B1;
    step(5); step(6); step(8); step(0);
    check("skip.err",  128'(err), 128'(1));
    check("skip.busy", 128'(busy), 128'(0));
    check("skip.valid", 128'(out_valid), 128'(0));
    for (int i = 0; i < 3; i++) begin
      step(0);
      check($sformatf("skip.novalid%0d", i), 128'(out_valid), 128'(0));
    end
    run_collect(B2);
    step(0);
    drain("skip_run", B2, -1, 0);
    check("skip.err_sticky", 128'(err), 128'(1));

    // Asynchronous reset in the middle of a collection
    cur_base = B1;
    for (int k = 5; k <= 9; k++) step(k);
    check("arst.busy_before", 128'(busy), 128'(1));
    #2 rst = 1'b1;
    #1 check_zero("arst");
    @(negedge clk);
    rst = 1'b0;
    step(0);
    check("arst.no_done", 128'(done), 128'(0));
    check("arst.idle",    128'(busy), 128'(0));
    run_collect(B2);
    step(0);
    drain("arst_run", B2, -1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
